aes_decrypt_iter: RTL
=====================

# aes_decrypt_iter

Iterative AES inverse cipher for all three FIPS-197 key sizes, selected by parameter. It holds its own sequential key expansion into an internal round-key store, so one key load serves any number of blocks. Ciphertext enters and plaintext leaves over valid/ready handshakes, one round per clock. It replaces the fixed-width, free-running decrypt datapath; the existing inverse round logic sits beneath it.

## Interface
- KEY_BITS, 128: key length; legal values 128, 192, 256. Gives Nk = KEY_BITS/32 and Nr = Nk+6.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- key_valid  in  1  key_in is offered
- key_in  in  KEY_BITS  cipher key, [0:KEY_BITS-1], byte 0 = bits 0:7
- key_ready  out  1  key load accepted this cycle when key_valid is also high
- keys_ok  out  1  round-key store is complete and valid
- in_valid  in  1  ciphertext is offered
- in_data  in  128  ciphertext block, [0:127], byte 0 = bits 0:7
- in_ready  out  1  block accepted when in_valid is also high
- out_valid  out  1  plaintext is valid
- out_data  out  128  plaintext block
- out_ready  in  1  downstream consumes the output

## Operation
- FSM states: NOKEY, KEYEXP, READY, ROUND, HOLD. Reset state is NOKEY.
- Reset values: all outputs are 0, round-key store contents are don't-care, keys_ok = 0.
- key_ready = 1 in NOKEY and READY.
- in_ready = 1 only in READY.
- Key load handshake: key_valid && key_ready.
  - Write words w[0..Nk-1] into the store. Word counter i = Nk. Clear keys_ok. Go to KEYEXP.
- KEYEXP: write one word per cycle.
  - Base rule: w[i] = w[i-Nk] ^ temp, where temp = w[i-1].
  - If i mod Nk == 0: temp = SubWord(RotWord(w[i-1])) ^ Rcon[i/Nk].
  - If Nk == 8 and i mod 8 == 4: temp = SubWord(w[i-1]).
  - After w[4*Nr+3] is written: set keys_ok = 1 and go to READY.
- READY, on accept (in_valid && in_ready): state <= in_data ^ rk[Nr], rnd <= Nr-1, go to ROUND.
- ROUND, one edge per round:
  - If rnd >= 1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[rnd]), then rnd <= rnd-1.
  - If rnd == 0: final round, with no InvMixColumns. out_data <= InvSubBytes(InvShiftRows(state)) ^ rk[0], out_valid <= 1, go to HOLD.
- HOLD: out_data stays stable while out_valid && !out_ready. On out_ready: out_valid <= 0, go to READY.
- rk[r] means the four words w[4r..4r+3], concatenated in big-endian order.
- A simultaneous key_valid and in_valid in READY loads the key; the block is not accepted.
- key_valid in KEYEXP, ROUND or HOLD is ignored because key_ready = 0. A new key never corrupts a block in flight.
- rst asserted at any point returns to NOKEY immediately. Any in-flight block and any partial expansion are discarded, and keys_ok is cleared.

## Timing
- Key expansion: 4(Nr+1)-Nk cycles after the load edge (40 / 46 / 52 for 128 / 192 / 256). keys_ok rises on the edge that writes the last word.
- Decrypt latency: out_valid rises Nr edges after the accept edge (10 / 12 / 14).
- Throughput: one block per Nr+2 cycles when out_ready is held high. The cycles are:
  - accept edge
  - Nr round edges
  - HOLD→READY edge
- No combinational path from in_valid or out_ready to any output. in_ready, key_ready and out_valid are decoded from state only.

## Structure
- Package aes_pkg holds:
  - sbox and inverse sbox constant functions
  - Rcon table
  - xtime / gf_mul helpers
  - function nr_of(KEY_BITS)
  - state-enum typedef
- Sub-module aes_inv_round, combinational: inputs state, rk, is_final; output next state. It is instantiated once.
- The round-key store is a 4(Nr+1) × 32 register array inside the top. One write port serves expansion; a 4-word read at rk index rnd serves the rounds.

## Test plan
- AES-128: load key 000102…0e0f, wait for keys_ok, send 69c4e0d86a7b0430d8cdb78070b4c55a → out_data 00112233445566778899aabbccddeeff on the 10th edge after accept.
- AES-192 (KEY_BITS=192): key 000102…1617, ciphertext dda97ca4864cdfe06eaf70a0ec0d7191 → 00112233…eeff. keys_ok must rise exactly 46 cycles after the load.
- AES-256: key 000102…1e1f, ciphertext 8ea2b7ca516745bfeafc49904b496089 → 00112233…eeff after 14 edges.
- Backpressure: hold out_ready = 0 for 20 cycles → out_data stable, in_ready = 0. After release, a back-to-back second block is accepted the cycle after the HOLD→READY edge.
- Key-load races:
  - key_valid during ROUND → ignored; the current block decrypts correctly.
  - key_valid and in_valid together in READY → the key is taken, in_ready falls, and the old block is not accepted.
- Reset mid-ROUND and mid-KEYEXP → all outputs 0, keys_ok = 0, in_ready = 0, and a new key must be loaded before any decryption.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES helpers for the iterative inverse cipher: the controller state
// enum, GF(2^8) arithmetic, forward/inverse S-box, the Rcon table and the
// round-count helper.
package aes_pkg;

    typedef enum logic [2:0] {
        NOKEY  = 3'd0,
        KEYEXP = 3'd1,
        READY  = 3'd2,
        ROUND  = 3'd3,
        HOLD   = 3'd4
    } state_t;

    // Number of rounds for a given key length (Nk + 6).
    function automatic int unsigned nr_of(input int unsigned key_bits);
        return key_bits / 32 + 6;
    endfunction

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    // Forward S-box: inverse followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Inverse S-box: inverse affine transform followed by the field inverse.
    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] b;
        b = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round, purely combinational.
//   state     : current 128-bit state, byte 0 in bits 127:120, column-major
//   rk        : round key for this round
//   is_final  : skip InvMixColumns (last round)
//   state_out : InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk), or the
//               same without InvMixColumns when is_final is set
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic         is_final,
    output logic [127:0] state_out
);

    logic [127:0] shifted;
    logic [127:0] subbed;
    logic [127:0] keyed;
    logic [127:0] mixed;
    logic [7:0]   a0, a1, a2, a3;

    // Byte n sits at row n%4, column n/4; InvShiftRows rotates row r right by r.
    always_comb begin
        shifted = '0;
        subbed  = '0;
        mixed   = '0;
        a0 = '0;
        a1 = '0;
        a2 = '0;
        a3 = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127-8*(r+4*c) -: 8] = state[127-8*(r+4*((c+4-r)%4)) -: 8];
            end
        end
        for (int b = 0; b < 16; b++) begin
            subbed[127-8*b -: 8] = inv_sbox(shifted[127-8*b -: 8]);
        end
        keyed = subbed ^ rk;
        for (int c = 0; c < 4; c++) begin
            a0 = keyed[127-8*(4*c)   -: 8];
            a1 = keyed[127-8*(4*c+1) -: 8];
            a2 = keyed[127-8*(4*c+2) -: 8];
            a3 = keyed[127-8*(4*c+3) -: 8];
            mixed[127-8*(4*c)   -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                                      ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            mixed[127-8*(4*c+1) -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                                      ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            mixed[127-8*(4*c+2) -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                                      ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            mixed[127-8*(4*c+3) -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                                      ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        state_out = is_final ? keyed : mixed;
    end

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher (128/192/256-bit keys via KEY_BITS).
// Expands the key one word per cycle into an internal store, then decrypts
// one block at a time, one round per clock.
//   clk, rst              : clock, asynchronous active-high reset
//   key_valid/key_ready   : key load handshake, key_in = cipher key (byte 0 = MSB)
//   keys_ok               : round-key store complete
//   in_valid/in_ready     : ciphertext handshake, in_data (byte 0 = MSB)
//   out_valid/out_ready   : plaintext handshake, out_data
module aes_decrypt_iter
    import aes_pkg::*;
#(
    parameter int unsigned KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                key_ready,
    output logic                keys_ok,
    input  logic                in_valid,
    input  logic [127:0]        in_data,
    output logic                in_ready,
    output logic                out_valid,
    output logic [127:0]        out_data,
    input  logic                out_ready
);

    localparam int unsigned NK = KEY_BITS / 32;
    localparam int unsigned NR = nr_of(KEY_BITS);
    localparam int unsigned NW = 4 * (NR + 1);
    localparam int unsigned IW = $clog2(NW);
    localparam int unsigned RW = $clog2(NR + 1);
    localparam int unsigned JW = 3;

    state_t        state, next;
    logic [31:0]   w [NW];
    logic [IW-1:0] cnt;
    logic [JW-1:0] j;
    logic [3:0]    rci;
    logic [RW-1:0] rnd;
    logic [127:0]  blk;
    logic [127:0]  rk;
    logic [127:0]  round_out;
    logic [31:0]   temp;
    logic [31:0]   new_word;
    logic [IW-1:0] rk_base;

    logic load_key, accept, exp_step, exp_last, round_step, round_final, release_out;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= NOKEY;
        else     state <= next;
    end

    // Next state and per-cycle control strobes; key load wins over a block.
    always_comb begin
        next        = state;
        load_key    = 1'b0;
        accept      = 1'b0;
        exp_step    = 1'b0;
        exp_last    = 1'b0;
        round_step  = 1'b0;
        round_final = 1'b0;
        release_out = 1'b0;
        case (state)
            NOKEY: begin
                if (key_valid) begin
                    load_key = 1'b1;
                    next     = KEYEXP;
                end
            end
            KEYEXP: begin
                exp_step = 1'b1;
                if (cnt == IW'(NW - 1)) begin
                    exp_last = 1'b1;
                    next     = READY;
                end
            end
            READY: begin
                if (key_valid) begin
                    load_key = 1'b1;
                    next     = KEYEXP;
                end else if (in_valid) begin
                    accept = 1'b1;
                    next   = ROUND;
                end
            end
            ROUND: begin
                if (rnd == '0) begin
                    round_final = 1'b1;
                    next        = HOLD;
                end else begin
                    round_step = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    release_out = 1'b1;
                    next        = READY;
                end
            end
            default: next = NOKEY;
        endcase
    end

    // Key schedule word: j tracks i mod Nk, rci tracks i / Nk.
    always_comb begin
        temp = w[cnt - IW'(1)];
        if (j == '0) begin
            temp = sub_word(rot_word(w[cnt - IW'(1)])) ^ {rcon(rci), 24'h000000};
        end else if (NK == 8 && j == JW'(4)) begin
            temp = sub_word(w[cnt - IW'(1)]);
        end
        new_word = w[cnt - IW'(NK)] ^ temp;
    end

    // Round-key read at index rnd (rnd sits at Nr while waiting in READY).
    assign rk_base = IW'({rnd, 2'b00});
    assign rk = {w[rk_base], w[rk_base + IW'(1)], w[rk_base + IW'(2)], w[rk_base + IW'(3)]};

    aes_inv_round u_round (
        .state     (blk),
        .rk        (rk),
        .is_final  (rnd == '0),
        .state_out (round_out)
    );

    // Round-key store: key load fills w[0..Nk-1], expansion writes w[cnt].
    always_ff @(posedge clk) begin
        if (load_key) begin
            for (int k = 0; k < int'(NK); k++) begin
                w[k] <= key_in[KEY_BITS-1-32*k -: 32];
            end
        end else if (exp_step) begin
            w[cnt] <= new_word;
        end
    end

    // Datapath, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            j         <= '0;
            rci       <= '0;
            rnd       <= '0;
            blk       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            keys_ok   <= 1'b0;
            key_ready <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            key_ready <= (next == NOKEY) || (next == READY);
            in_ready  <= (next == READY);
            out_valid <= (next == HOLD);
            if (load_key) begin
                cnt     <= IW'(NK);
                j       <= '0;
                rci     <= 4'd1;
                keys_ok <= 1'b0;
            end else if (exp_step) begin
                cnt <= cnt + IW'(1);
                if (j == JW'(NK - 1)) begin
                    j   <= '0;
                    rci <= rci + 4'd1;
                end else begin
                    j <= j + JW'(1);
                end
                if (exp_last) begin
                    keys_ok <= 1'b1;
                    rnd     <= RW'(NR);
                end
            end
            if (accept) begin
                blk <= in_data ^ rk;
                rnd <= RW'(NR - 1);
            end
            if (round_step) begin
                blk <= round_out;
                rnd <= rnd - RW'(1);
            end
            if (round_final) out_data <= round_out;
            if (release_out) rnd <= RW'(NR);
        end
    end

endmodule
